vram_write_queue: RTL and testbench

//   Buffers CPU (Avalon-MM slave) writes to the graphics register space in an
//   in-order FIFO. Replays them to the downstream address decoder only while
//   the display is in vertical blank, so tile/sprite/palette/OAM memories never

---
 rtl/vram_write_queue.sv | 152 +++++++++++++++
 tb/tb_vram_write_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_queue.sv
// vram_write_queue
//
// Holds CPU writes aimed at the graphics register space in an in-order FIFO.
// The queued writes are replayed to the address decoder only while the gate
// is open, which is vertical blank by default. This keeps the tile, sprite,
// palette and OAM memories from changing in the middle of a frame.
//
// Ports
//   clk              system clock
//   reset_n          asynchronous active-low reset
//   s_chipselect     Avalon slave select
//   s_write          Avalon write strobe
//   s_address        Avalon word address          [ADDR_W]
//   s_writedata      Avalon write data            [DATA_W]
//   s_waitrequest    stalls the CPU while the FIFO is full
//   vblank           vertical blank, from the VGA timing block
//   out_chip_select  decoder chip_select (registered)
//   out_write        decoder write (registered)
//   out_addr         decoder addr, zero when idle [ADDR_W]
//   out_write_data   decoder write_data, zero when idle [DATA_W]
//   fill_level       number of queued entries     [$clog2(DEPTH)+1]
//   drain_active     high while the FSM is in DRAIN
//
// FSM states
//   state | meaning
//   IDLE  | holding entries, or empty; nothing is popped
//   DRAIN | gate open; one entry is popped per cycle while the queue is non-empty

`timescale 1ns/1ps

module vram_write_queue #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int GATE_VBLANK = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       s_chipselect,
    input  logic                       s_write,
    input  logic [ADDR_W-1:0]          s_address,
    input  logic [DATA_W-1:0]          s_writedata,
    output logic                       s_waitrequest,
    input  logic                       vblank,
    output logic                       out_chip_select,
    output logic                       out_write,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [DATA_W-1:0]          out_write_data,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       drain_active
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                     state, state_next;
    logic [ADDR_W+DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       gate_open;
    logic                       push, pop;

    // The full flag comes from the registered count, so a pop in the same
    // cycle does not open a slot until the following cycle.
    assign s_waitrequest = (count == CNT_W'(DEPTH));
    assign gate_open     = (GATE_VBLANK != 0) ? vblank : 1'b1;
    assign push          = s_chipselect & s_write & ~s_waitrequest;
    assign pop           = (state == DRAIN) & (count != '0) & gate_open;

    assign fill_level    = count;
    assign drain_active  = (state == DRAIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if ((count != '0) && gate_open) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!gate_open) begin
                    state_next = IDLE;
                end else if ((count == CNT_W'(1)) && pop && !push) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The storage needs no reset. After a reset the pointers and count are
    // cleared, so stale contents can never be read out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_address, s_writedata};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_chip_select <= 1'b0;
            out_write       <= 1'b0;
            out_addr        <= '0;
            out_write_data  <= '0;
        end else begin
            out_chip_select <= pop;
            out_write       <= pop;
            if (pop) begin
                {out_addr, out_write_data} <= mem[rd_ptr];
            end else begin
                out_addr       <= '0;
                out_write_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vram_write_queue.sv
`timescale 1ns/1ps

module tb_vram_write_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_chipselect, s_write;
    logic [11:0] s_address;
    logic [31:0] s_writedata;
    logic        s_waitrequest;
    logic        vblank;
    logic        out_chip_select, out_write;
    logic [11:0] out_addr;
    logic [31:0] out_write_data;
    logic [4:0]  fill_level;
    logic        drain_active;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int accept_cyc;

    logic [44:0] obs_q[$];
    int          obs_cyc[$];

    vram_write_queue #(.DEPTH(16), .ADDR_W(12), .DATA_W(32), .GATE_VBLANK(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_chipselect(s_chipselect), .s_write(s_write),
        .s_address(s_address), .s_writedata(s_writedata),
        .s_waitrequest(s_waitrequest), .vblank(vblank),
        .out_chip_select(out_chip_select), .out_write(out_write),
        .out_addr(out_addr), .out_write_data(out_write_data),
        .fill_level(fill_level), .drain_active(drain_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every issued write as {chip_select, addr, data} with its cycle number.
    always @(negedge clk) begin
        if (out_write === 1'b1) begin
            obs_q.push_back({out_chip_select, out_addr, out_write_data});
            obs_cyc.push_back(cyc);
        end
    end

    task automatic push(input logic [11:0] a, input logic [31:0] d);
        int waited = 0;
        @(negedge clk);
        s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
        while (s_waitrequest && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (s_waitrequest) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout: waitrequest=%0b required 0 within 200 cycles", s_waitrequest);
        end
        accept_cyc = cyc;
        @(posedge clk);
    endtask

    task automatic bus_idle();
        @(negedge clk);
        s_chipselect = 1'b0; s_write = 1'b0; s_address = '0; s_writedata = '0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_obs(input string name, input int idx, input logic [11:0] a, input logic [31:0] d);
        n_cmp++;
        if (idx >= obs_q.size()) begin
            n_bad++;
            $display("FAIL %s[%0d]: missing, got %0d writes", name, idx, obs_q.size());
        end else if (obs_q[idx] !== {1'b1, a, d}) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h required %h", name, idx, obs_q[idx], {1'b1, a, d});
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; s_chipselect = 0; s_write = 0; s_address = 0; s_writedata = 0; vblank = 0;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(2);
        n_cmp++;
        if ({s_waitrequest, out_chip_select, out_write, out_addr, out_write_data, fill_level, drain_active} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: wr=%b cs=%b w=%b a=%h d=%h fl=%0d da=%b required all 0",
                     s_waitrequest, out_chip_select, out_write, out_addr, out_write_data, fill_level, drain_active);
        end
    endtask

    task automatic test_gated_drain();
        logic [11:0] ea [3];
        logic [31:0] ed [3];
        ea = '{12'h010, 12'h420, 12'hE05};
        ed = '{32'hA, 32'hB, 32'hC};
        obs_q.delete(); obs_cyc.delete();
        for (int i = 0; i < 3; i++) push(ea[i], ed[i]);
        bus_idle();
        wait_cycles(5);
        n_cmp++;
        if (obs_q.size() != 0 || fill_level !== 5'd3) begin
            n_bad++;
            $display("FAIL gated_hold: writes=%0d fill=%0d required 0 and 3", obs_q.size(), fill_level);
        end
        vblank = 1'b1;
        wait_cycles(8);
        for (int i = 0; i < 3; i++) check_obs("gated_order", i, ea[i], ed[i]);
        n_cmp++;
        if (obs_q.size() != 3 || obs_cyc[1] != obs_cyc[0] + 1 || obs_cyc[2] != obs_cyc[0] + 2) begin
            n_bad++;
            $display("FAIL gated_consecutive: count=%0d required 3 consecutive", obs_q.size());
        end
        n_cmp++;
        if (fill_level !== 5'd0 || drain_active !== 1'b0) begin
            n_bad++;
            $display("FAIL gated_end: fill=%0d drain=%b required 0 0", fill_level, drain_active);
        end
        vblank = 1'b0;
    endtask

    task automatic test_full_stall();
        int k = 0;
        obs_q.delete(); obs_cyc.delete();
        for (int i = 0; i < 16; i++) push(12'h100 + 12'(i), 32'h2000_0000 + i);
        @(negedge clk);
        n_cmp++;
        if (s_waitrequest !== 1'b1 || fill_level !== 5'd16) begin
            n_bad++;
            $display("FAIL full_flag: waitrequest=%b fill=%0d required 1 16", s_waitrequest, fill_level);
        end
        s_address = 12'h110; s_writedata = 32'h2000_0010;
        vblank = 1'b1;
        while (s_waitrequest && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k != 2 || out_write !== 1'b1) begin
            n_bad++;
            $display("FAIL full_release: accepted after %0d cycles out_write=%b required 2 and 1", k, out_write);
        end
        @(posedge clk);
        bus_idle();
        wait_cycles(25);
        for (int i = 0; i < 17; i++) check_obs("full_order", i, 12'h100 + 12'(i), 32'h2000_0000 + i);
        vblank = 1'b0;
    endtask

    task automatic test_latency();
        obs_q.delete(); obs_cyc.delete();
        vblank = 1'b1;
        push(12'h3C7, 32'hDEAD_BEEF);
        bus_idle();
        wait_cycles(8);
        check_obs("latency_data", 0, 12'h3C7, 32'hDEAD_BEEF);
        n_cmp++;
        if (obs_q.size() != 1 || obs_cyc[0] != accept_cyc + 3) begin
            n_bad++;
            $display("FAIL latency_cycle: writes=%0d at cycle %0d required 1 at %0d",
                     obs_q.size(), (obs_cyc.size() > 0) ? obs_cyc[0] : -1, accept_cyc + 3);
        end
        vblank = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_vblank_tail();
        obs_q.delete(); obs_cyc.delete();
        for (int i = 0; i < 8; i++) push(12'h800 + 12'(i), 32'h4400_0000 + i);
        bus_idle();
        wait_cycles(2);
        vblank = 1'b1;
        wait_cycles(4);
        vblank = 1'b0;
        wait_cycles(6);
        n_cmp++;
        if (obs_q.size() != 3 || fill_level !== 5'd5 || drain_active !== 1'b0) begin
            n_bad++;
            $display("FAIL tail_partial: writes=%0d fill=%0d drain=%b required 3 5 0",
                     obs_q.size(), fill_level, drain_active);
        end
        vblank = 1'b1;
        wait_cycles(10);
        for (int i = 0; i < 8; i++) check_obs("tail_order", i, 12'h800 + 12'(i), 32'h4400_0000 + i);
        n_cmp++;
        if (obs_q.size() != 8 || fill_level !== 5'd0) begin
            n_bad++;
            $display("FAIL tail_final: writes=%0d fill=%0d required 8 0", obs_q.size(), fill_level);
        end
        vblank = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bad_fill = 0;
        obs_q.delete(); obs_cyc.delete();
        vblank = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(12'((i * 7) % 4096), 32'hC0DE_0000 + i);
            #1;
            if (i >= 1 && fill_level !== 5'd2) bad_fill++;
        end
        bus_idle();
        wait_cycles(8);
        n_cmp++;
        if (bad_fill != 0) begin
            n_bad++;
            $display("FAIL stream_fill: %0d cycles with fill != 2, required 0", bad_fill);
        end
        for (int i = 0; i < 40; i++) check_obs("stream_order", i, 12'((i * 7) % 4096), 32'hC0DE_0000 + i);
        n_cmp++;
        if (obs_q.size() != 40) begin
            n_bad++;
            $display("FAIL stream_count: writes=%0d required 40", obs_q.size());
        end
        vblank = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 8; i++) push(12'h600 + 12'(i), 32'h6600_0000 + i);
        bus_idle();
        wait_cycles(2);
        vblank = 1'b1;
        wait_cycles(4);
        n_cmp++;
        if (fill_level !== 5'd5 || drain_active !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset: fill=%0d drain=%b required 5 1", fill_level, drain_active);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({s_waitrequest, out_chip_select, out_write, out_addr, out_write_data, fill_level, drain_active} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: cs=%b w=%b a=%h d=%h fl=%0d da=%b required all 0",
                     out_chip_select, out_write, out_addr, out_write_data, fill_level, drain_active);
        end
        obs_q.delete(); obs_cyc.delete();
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(10);
        n_cmp++;
        if (obs_q.size() != 0 || fill_level !== 5'd0) begin
            n_bad++;
            $display("FAIL post_reset: writes=%0d fill=%0d required 0 0", obs_q.size(), fill_level);
        end
        vblank = 1'b0;
    endtask

    initial begin
        test_reset();
        test_gated_drain();
        test_full_stall();
        test_latency();
        test_vblank_tail();
        test_back_to_back();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
